// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared state encodings, glyph table and default timing for the scan controller
package display_pkg;

  localparam int DIV_DEFAULT   = 4;
  localparam int BLANK_DEFAULT = 1;

  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_BLANK = 2'd1,
    ST_ON    = 2'd2
  } scan_state_t;

  // Segment order {g,f,e,d,c,b,a}, active high; entries 0-9 decimal, A-F hex.
  localparam logic [6:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/display_scan_controller_if.sv
// rtl/display_scan_controller_if.sv - frame load handshake and multiplexed display outputs
interface display_scan_controller_if;

  logic        en;
  logic        lzb;
  logic        load_valid;
  logic [15:0] load_data;
  logic        load_ready;
  logic        d0;
  logic        d1;
  logic        d2;
  logic        d3;
  logic [6:0]  seg;
  logic        frame_done;

  modport master (
    output en, lzb, load_valid, load_data,
    input  load_ready, d0, d1, d2, d3, seg, frame_done
  );

  modport slave (
    input  en, lzb, load_valid, load_data,
    output load_ready, d0, d1, d2, d3, seg, frame_done
  );

endinterface

// File: rtl/seg7_decoder.sv
// rtl/seg7_decoder.sv - combinational hex digit to seven-segment glyph lookup
module seg7_decoder
  import display_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  assign seg = GLYPH[code];

endmodule

// File: rtl/display_scan_controller.sv
// rtl/display_scan_controller.sv - four-digit multiplexed seven-segment scan controller with frame double buffering
module display_scan_controller
  import display_pkg::*;
#(
  parameter int DIV   = DIV_DEFAULT,
  parameter int BLANK = BLANK_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  display_scan_controller_if.slave bus
);

  localparam int             CW         = $clog2(DIV);
  localparam logic [CW-1:0]  SLOT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0]  BLANK_LAST = CW'(BLANK - 1);

  scan_state_t   state_q, state_d;
  logic [CW-1:0] slot_q, slot_d;
  logic [1:0]    idx_q, idx_d;

  logic [15:0]   active_q;
  logic [15:0]   pend_q;
  logic          pend_full_q;
  logic          lzb_q;

  logic          slot_wrap;
  logic          frame_done;
  logic          accept;
  logic          xfer;

  logic [3:0]    code;
  logic          lead_zero;
  logic          lit;
  logic [6:0]    glyph;

  assign slot_wrap  = (slot_q == SLOT_LAST);
  assign frame_done = (state_q == ST_ON) && (idx_q == 2'd3) && slot_wrap;

  // Scan state, slot counter and digit index registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_HALT;
      slot_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      idx_q   <= idx_d;
    end
  end

  // Next scan state: dead time at the start of every slot, lit for the rest, halt whenever disabled
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    idx_d   = idx_q;
    if (!bus.en) begin
      state_d = ST_HALT;
      slot_d  = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        ST_HALT: begin
          state_d = ST_BLANK;
          slot_d  = '0;
          idx_d   = '0;
        end
        ST_BLANK, ST_ON: begin
          if (slot_wrap) begin
            state_d = ST_BLANK;
            slot_d  = '0;
            idx_d   = idx_q + 2'd1;
          end else begin
            slot_d = slot_q + 1'b1;
            if (state_q == ST_BLANK && slot_q == BLANK_LAST) begin
              state_d = ST_ON;
            end
          end
        end
        default: begin
          state_d = ST_HALT;
          slot_d  = '0;
          idx_d   = '0;
        end
      endcase
    end
  end

  // A new frame waits in the pending register so a digit never changes mid-frame while scanning;
  // with the scan halted there is no frame boundary to wait for, so it is applied at once.
  assign accept = bus.load_valid && !pend_full_q;
  assign xfer   = pend_full_q && (frame_done || !bus.en);

  // Pending/active frame registers and the registered blanking enable
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q      <= '0;
      active_q    <= '0;
      pend_full_q <= 1'b0;
      lzb_q       <= 1'b0;
    end else begin
      lzb_q <= bus.lzb;
      if (accept) begin
        pend_q      <= bus.load_data;
        pend_full_q <= 1'b1;
      end else if (xfer) begin
        active_q    <= pend_q;
        pend_full_q <= 1'b0;
      end
    end
  end

  // Select the active digit code and whether it and everything above it is zero
  always_comb begin
    code      = active_q[3:0];
    lead_zero = 1'b0;
    case (idx_q)
      2'd0: begin
        code      = active_q[3:0];
        lead_zero = 1'b0;
      end
      2'd1: begin
        code      = active_q[7:4];
        lead_zero = (active_q[15:4] == 12'h000);
      end
      2'd2: begin
        code      = active_q[11:8];
        lead_zero = (active_q[15:8] == 8'h00);
      end
      default: begin
        code      = active_q[15:12];
        lead_zero = (active_q[15:12] == 4'h0);
      end
    endcase
  end

  seg7_decoder u_seg7_decoder (
    .code (code),
    .seg  (glyph)
  );

  // Outputs depend only on registered state, so input changes never glitch the display directly.
  assign lit            = (state_q == ST_ON) && !(lzb_q && lead_zero);
  assign bus.seg        = lit ? glyph : 7'h00;
  assign bus.d0         = lit && (idx_q == 2'd0);
  assign bus.d1         = lit && (idx_q == 2'd1);
  assign bus.d2         = lit && (idx_q == 2'd2);
  assign bus.d3         = lit && (idx_q == 2'd3);
  assign bus.frame_done = frame_done;
  assign bus.load_ready = !pend_full_q;

endmodule
